mma_icb_mux: RTL and testbench
==============================

// Module: mma_icb_mux
// PURPOSE
// - Shared-ICB command mux and response router behind the MMA ICB arbiter.
// - Forwards the command channel of the granted requester (IA/kernel/bias loader, vec requant, OA writer) to the single ICB master port.
// - Records the issuing requester of every accepted command in an in-order ID FIFO; routes each ICB response back to that requester.
// - Responses return correctly even after the grant has moved on.
// PARAMETERS
// NUM_MST   5   number of requesters; index = arbiter icb_sel encoding
// AW        32  ICB address width
// DW        32  ICB data width
// MAX_OUTS  4   max outstanding commands (ID FIFO depth, power of 2, >=2)
// PORTS
// clk             in   1              clock
// rst_n           in   1              async active-low reset
// sel             in   3              granted requester index (arbiter icb_sel)
// sel_vld         in   1              any requester currently granted
// m_cmd_valid     in   NUM_MST        per-requester cmd valid
// m_cmd_ready     out  NUM_MST        per-requester cmd ready
// m_cmd_addr      in   NUM_MST*AW     per-requester address, requester i at [i*AW +: AW]
// m_cmd_read      in   NUM_MST        per-requester read(1)/write(0)
// m_cmd_wdata     in   NUM_MST*DW     per-requester write data
// m_cmd_wmask     in   NUM_MST*DW/8   per-requester byte mask
// m_rsp_valid     out  NUM_MST        per-requester rsp valid
// m_rsp_ready     in   NUM_MST        per-requester rsp ready
// m_rsp_rdata     out  DW             rsp data, broadcast to all requesters
// m_rsp_err       out  1              rsp error, broadcast to all requesters
// icb_cmd_valid   out  1              shared ICB cmd valid
// icb_cmd_ready   in   1              shared ICB cmd ready
// icb_cmd_addr    out  AW             shared ICB address
// icb_cmd_read    out  1              shared ICB read flag
// icb_cmd_wdata   out  DW             shared ICB write data
// icb_cmd_wmask   out  DW/8           shared ICB byte mask
// icb_rsp_valid   in   1              shared ICB rsp valid
// icb_rsp_ready   out  1              shared ICB rsp ready
// icb_rsp_rdata   in   DW             shared ICB rsp data
// icb_rsp_err     in   1              shared ICB rsp error
// outs_cnt        out  $clog2(MAX_OUTS)+1  outstanding command count
// idle            out  1              outs_cnt==0
// orphan_rsp      out  1              sticky: response seen with empty FIFO
// BEHAVIOUR
// - Reset (async, rst_n low): FIFO pointers=0, outs_cnt=0, orphan_rsp=0.
//   Reset values of outputs: idle=1, all cmd/rsp valids=0; icb_rsp_ready=1 because the FIFO is empty (orphan drain).
// - A reset mid-operation discards all outstanding IDs; responses arriving later are treated as orphans.
// - cmd_path (combinational, 0-cycle latency):
//   - fwd = sel_vld && sel<NUM_MST && !full.
//   - icb_cmd_valid = fwd && m_cmd_valid[sel]; addr/read/wdata/wmask are muxed from requester sel (zero when !fwd).
//   - m_cmd_ready[sel] = fwd && icb_cmd_ready; all other m_cmd_ready bits = 0.
// - push: on icb_cmd_valid&&icb_cmd_ready, write sel into FIFO[wptr]; wptr wraps modulo MAX_OUTS.
// - full = (outs_cnt==MAX_OUTS). No push when full, even if a pop happens in the same cycle (ready is low for that cycle).
// - rsp_path, FIFO non-empty:
//   - head = FIFO[rptr].
//   - m_rsp_valid[head] = icb_rsp_valid; all other bits = 0.
//   - icb_rsp_ready = m_rsp_ready[head].
// - pop: on icb_rsp_valid&&icb_rsp_ready, rptr wraps modulo MAX_OUTS.
// - Simultaneous push and pop: outs_cnt unchanged, both pointers advance.
// - rsp_path, FIFO empty: m_rsp_valid=0 and icb_rsp_ready=1, so the response is dropped. orphan_rsp is set at the next edge and stays set until reset.
// - sel change while commands are outstanding is legal. New commands go to the new requester; old responses still route by FIFO order.
// - sel_vld=0 or sel>=NUM_MST: no command forwarded; the response path is unaffected.
// - Ordering: the ICB slave returns responses in command order. No reordering support.
// TESTING
// - sel=1, kernel loader issues 3 reads with icb_cmd_ready=1 -> outs_cnt 1,2,3. Responses D0..D2 reach only m_rsp_valid[1] in order; idle=1 afterwards.
// - MAX_OUTS=4, sel=0, 4 cmds with no rsp -> m_cmd_ready[0]=0 on the 5th. Then 1 rsp plus a 5th cmd in the same cycle -> cmd is held that cycle and accepted the next.
// - sel=2 issues 2 cmds, then sel switches to 4 and issues 1 cmd -> rsps are routed to requesters 2,2,4 in that order.
// - icb_rsp_valid=1 with outs_cnt=0 -> icb_rsp_ready=1, no m_rsp_valid asserted, orphan_rsp=1 on the next edge and sticky.
// - sel=3, m_rsp_ready[3]=0 for 5 cycles -> icb_rsp_ready=0 and outs_cnt holds for those cycles. A push in the same window raises outs_cnt by 1.
// - Assert rst_n=0 with 2 cmds outstanding -> outs_cnt=0, idle=1 immediately; the next stray rsp sets orphan_rsp.

Source files
------------

// File: rtl/mma_icb_mux.sv
// Shared-ICB command mux and in-order response router for the MMA block.
// The granted requester's command is forwarded to the single ICB master port.
// Every accepted command records its requester index in an ID FIFO, so each
// response is routed by issue order and not by the current grant.
module mma_icb_mux #(
    parameter int NUM_MST  = 5,
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_OUTS = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [2:0]                    sel,
    input  logic                          sel_vld,
    input  logic [NUM_MST-1:0]            m_cmd_valid,
    output logic [NUM_MST-1:0]            m_cmd_ready,
    input  logic [NUM_MST*AW-1:0]         m_cmd_addr,
    input  logic [NUM_MST-1:0]            m_cmd_read,
    input  logic [NUM_MST*DW-1:0]         m_cmd_wdata,
    input  logic [NUM_MST*DW/8-1:0]       m_cmd_wmask,
    output logic [NUM_MST-1:0]            m_rsp_valid,
    input  logic [NUM_MST-1:0]            m_rsp_ready,
    output logic [DW-1:0]                 m_rsp_rdata,
    output logic                          m_rsp_err,
    output logic                          icb_cmd_valid,
    input  logic                          icb_cmd_ready,
    output logic [AW-1:0]                 icb_cmd_addr,
    output logic                          icb_cmd_read,
    output logic [DW-1:0]                 icb_cmd_wdata,
    output logic [DW/8-1:0]               icb_cmd_wmask,
    input  logic                          icb_rsp_valid,
    output logic                          icb_rsp_ready,
    input  logic [DW-1:0]                 icb_rsp_rdata,
    input  logic                          icb_rsp_err,
    output logic [$clog2(MAX_OUTS):0]     outs_cnt,
    output logic                          idle,
    output logic                          orphan_rsp
);

    localparam int PW = $clog2(MAX_OUTS);
    localparam int CW = PW + 1;

    logic [2:0]    id_mem [MAX_OUTS];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [2:0]    head;
    logic          full;
    logic          empty;
    logic          fwd;
    logic          push;
    logic          pop;

    assign full  = (outs_cnt == CW'(MAX_OUTS));
    assign empty = (outs_cnt == '0);
    assign idle  = empty;
    assign fwd   = sel_vld && (int'(sel) < NUM_MST) && !full;
    assign head  = id_mem[rptr];
    assign push  = icb_cmd_valid && icb_cmd_ready;
    // An orphan response is accepted on the bus but never pops the FIFO.
    assign pop   = icb_rsp_valid && icb_rsp_ready && !empty;

    assign m_rsp_rdata = icb_rsp_rdata;
    assign m_rsp_err   = icb_rsp_err;

    // Command mux: forward the granted requester, drive zeros otherwise.
    always_comb begin
        icb_cmd_valid = 1'b0;
        icb_cmd_addr  = '0;
        icb_cmd_read  = 1'b0;
        icb_cmd_wdata = '0;
        icb_cmd_wmask = '0;
        m_cmd_ready   = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            if (fwd && int'(sel) == i) begin
                icb_cmd_valid  = m_cmd_valid[i];
                icb_cmd_addr   = m_cmd_addr[i*AW +: AW];
                icb_cmd_read   = m_cmd_read[i];
                icb_cmd_wdata  = m_cmd_wdata[i*DW +: DW];
                icb_cmd_wmask  = m_cmd_wmask[i*(DW/8) +: DW/8];
                m_cmd_ready[i] = icb_cmd_ready;
            end
        end
    end

    // Response router: steer to the FIFO head, or drain when nothing is outstanding.
    always_comb begin
        m_rsp_valid   = '0;
        icb_rsp_ready = 1'b1;
        if (!empty) begin
            icb_rsp_ready = 1'b0;
            for (int i = 0; i < NUM_MST; i++) begin
                if (int'(head) == i) begin
                    m_rsp_valid[i] = icb_rsp_valid;
                    icb_rsp_ready  = m_rsp_ready[i];
                end
            end
        end
    end

    // ID FIFO storage: record the issuing requester of each accepted command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_OUTS; i++) id_mem[i] <= '0;
        end else if (push) begin
            id_mem[wptr] <= sel;
        end
    end

    // FIFO pointers and outstanding count; power-of-2 depth wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            outs_cnt <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            case ({push, pop})
                2'b10:   outs_cnt <= outs_cnt + CW'(1);
                2'b01:   outs_cnt <= outs_cnt - CW'(1);
                default: outs_cnt <= outs_cnt;
            endcase
        end
    end

    // Sticky flag for a response that arrived with no command outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      orphan_rsp <= 1'b0;
        else if (icb_rsp_valid && empty) orphan_rsp <= 1'b1;
    end

endmodule

// File: tb/tb_mma_icb_mux.sv
// Directed bench for mma_icb_mux: one task per scenario, inline checks.
module tb_mma_icb_mux;

    localparam int NUM_MST  = 5;
    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int MAX_OUTS = 4;

    logic                    clk;
    logic                    rst_n;
    logic [2:0]              sel;
    logic                    sel_vld;
    logic [NUM_MST-1:0]      m_cmd_valid;
    logic [NUM_MST-1:0]      m_cmd_ready;
    logic [NUM_MST*AW-1:0]   m_cmd_addr;
    logic [NUM_MST-1:0]      m_cmd_read;
    logic [NUM_MST*DW-1:0]   m_cmd_wdata;
    logic [NUM_MST*DW/8-1:0] m_cmd_wmask;
    logic [NUM_MST-1:0]      m_rsp_valid;
    logic [NUM_MST-1:0]      m_rsp_ready;
    logic [DW-1:0]           m_rsp_rdata;
    logic                    m_rsp_err;
    logic                    icb_cmd_valid;
    logic                    icb_cmd_ready;
    logic [AW-1:0]           icb_cmd_addr;
    logic                    icb_cmd_read;
    logic [DW-1:0]           icb_cmd_wdata;
    logic [DW/8-1:0]         icb_cmd_wmask;
    logic                    icb_rsp_valid;
    logic                    icb_rsp_ready;
    logic [DW-1:0]           icb_rsp_rdata;
    logic                    icb_rsp_err;
    logic [2:0]              outs_cnt;
    logic                    idle;
    logic                    orphan_rsp;

    int n_chk  = 0;
    int n_fail = 0;

    mma_icb_mux #(.NUM_MST(NUM_MST), .AW(AW), .DW(DW), .MAX_OUTS(MAX_OUTS)) dut (
        .clk(clk), .rst_n(rst_n), .sel(sel), .sel_vld(sel_vld),
        .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready), .m_cmd_addr(m_cmd_addr),
        .m_cmd_read(m_cmd_read), .m_cmd_wdata(m_cmd_wdata), .m_cmd_wmask(m_cmd_wmask),
        .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready), .m_rsp_rdata(m_rsp_rdata),
        .m_rsp_err(m_rsp_err), .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
        .icb_cmd_addr(icb_cmd_addr), .icb_cmd_read(icb_cmd_read), .icb_cmd_wdata(icb_cmd_wdata),
        .icb_cmd_wmask(icb_cmd_wmask), .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
        .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_err(icb_rsp_err), .outs_cnt(outs_cnt),
        .idle(idle), .orphan_rsp(orphan_rsp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        sel = '0; sel_vld = 1'b0; m_cmd_valid = '0; m_cmd_addr = '0; m_cmd_read = '0;
        m_cmd_wdata = '0; m_cmd_wmask = '0; m_rsp_ready = '1; icb_cmd_ready = 1'b1;
        icb_rsp_valid = 1'b0; icb_rsp_rdata = '0; icb_rsp_err = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        #1;
        n_chk++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle got %b exp 1", idle); end
        n_chk++; if (outs_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_outs got %0d exp 0", outs_cnt); end
        n_chk++; if (icb_cmd_valid !== 1'b0 || m_rsp_valid !== 5'b0) begin n_fail++; $display("FAIL reset_valids got cmd=%b rsp=%b exp 0/0", icb_cmd_valid, m_rsp_valid); end
        n_chk++; if (icb_rsp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rsp_ready got %b exp 1", icb_rsp_ready); end
        n_chk++; if (orphan_rsp !== 1'b0) begin n_fail++; $display("FAIL reset_orphan got %b exp 0", orphan_rsp); end
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_reads();
        logic [31:0] dat [3];
        dat[0] = 32'hD000_0000; dat[1] = 32'hD111_1111; dat[2] = 32'hD222_2222;
        sel = 3'd1; sel_vld = 1'b1; m_cmd_read = 5'b00010; icb_cmd_ready = 1'b1;
        m_cmd_valid = 5'b00010;
        for (int k = 0; k < 3; k++) begin
            m_cmd_addr[1*AW +: AW] = 32'h100 + 32'(4*k);
            #1;
            n_chk++; if (icb_cmd_valid !== 1'b1 || icb_cmd_addr !== 32'h100 + 32'(4*k) || icb_cmd_read !== 1'b1)
                begin n_fail++; $display("FAIL rd_cmd%0d got v=%b a=%h r=%b exp 1/%h/1", k, icb_cmd_valid, icb_cmd_addr, icb_cmd_read, 32'h100 + 32'(4*k)); end
            n_chk++; if (m_cmd_ready !== 5'b00010) begin n_fail++; $display("FAIL rd_cmd_ready%0d got %b exp 00010", k, m_cmd_ready); end
            cyc();
            n_chk++; if (outs_cnt !== 3'(k+1)) begin n_fail++; $display("FAIL rd_outs%0d got %0d exp %0d", k, outs_cnt, k+1); end
        end
        m_cmd_valid = '0;
        for (int k = 0; k < 3; k++) begin
            icb_rsp_valid = 1'b1; icb_rsp_rdata = dat[k];
            #1;
            n_chk++; if (m_rsp_valid !== 5'b00010 || m_rsp_rdata !== dat[k] || icb_rsp_ready !== 1'b1)
                begin n_fail++; $display("FAIL rd_rsp%0d got v=%b d=%h rdy=%b exp 00010/%h/1", k, m_rsp_valid, m_rsp_rdata, icb_rsp_ready, dat[k]); end
            cyc();
        end
        icb_rsp_valid = 1'b0;
        #1;
        n_chk++; if (idle !== 1'b1 || outs_cnt !== 3'd0) begin n_fail++; $display("FAIL rd_idle got idle=%b outs=%0d exp 1/0", idle, outs_cnt); end
        // No grant: nothing forwarded, address zeroed.
        sel_vld = 1'b0; m_cmd_valid = 5'b00010;
        #1;
        n_chk++; if (icb_cmd_valid !== 1'b0 || icb_cmd_addr !== 32'h0 || m_cmd_ready !== 5'b0)
            begin n_fail++; $display("FAIL no_grant got v=%b a=%h rdy=%b exp 0/0/0", icb_cmd_valid, icb_cmd_addr, m_cmd_ready); end
        sel_vld = 1'b1; sel = 3'd5; m_cmd_valid = 5'b11111;
        #1;
        n_chk++; if (icb_cmd_valid !== 1'b0 || m_cmd_ready !== 5'b0)
            begin n_fail++; $display("FAIL sel_oob got v=%b rdy=%b exp 0/0", icb_cmd_valid, m_cmd_ready); end
        cyc();
        n_chk++; if (outs_cnt !== 3'd0) begin n_fail++; $display("FAIL sel_oob_outs got %0d exp 0", outs_cnt); end
        clear_inputs();
    endtask

    task automatic test_full();
        sel = 3'd0; sel_vld = 1'b1; m_cmd_valid = 5'b00001;
        m_cmd_wdata[0 +: DW] = 32'hCAFE_F00D; m_cmd_wmask[0 +: 4] = 4'b0110;
        #1;
        n_chk++; if (icb_cmd_wdata !== 32'hCAFE_F00D || icb_cmd_wmask !== 4'b0110 || icb_cmd_read !== 1'b0)
            begin n_fail++; $display("FAIL wr_fields got d=%h m=%b r=%b exp cafef00d/0110/0", icb_cmd_wdata, icb_cmd_wmask, icb_cmd_read); end
        for (int k = 0; k < 4; k++) cyc();
        n_chk++; if (outs_cnt !== 3'd4) begin n_fail++; $display("FAIL full_outs got %0d exp 4", outs_cnt); end
        n_chk++; if (m_cmd_ready !== 5'b0 || icb_cmd_valid !== 1'b0) begin n_fail++; $display("FAIL full_block got rdy=%b v=%b exp 0/0", m_cmd_ready, icb_cmd_valid); end
        icb_rsp_valid = 1'b1;
        #1;
        n_chk++; if (m_rsp_valid !== 5'b00001 || m_cmd_ready !== 5'b0) begin n_fail++; $display("FAIL full_pop_cycle got rv=%b rdy=%b exp 00001/0", m_rsp_valid, m_cmd_ready); end
        cyc();
        icb_rsp_valid = 1'b0;
        n_chk++; if (outs_cnt !== 3'd3) begin n_fail++; $display("FAIL full_after_pop got %0d exp 3", outs_cnt); end
        #1;
        n_chk++; if (m_cmd_ready !== 5'b00001) begin n_fail++; $display("FAIL full_reaccept got %b exp 00001", m_cmd_ready); end
        cyc();
        m_cmd_valid = '0;
        n_chk++; if (outs_cnt !== 3'd4) begin n_fail++; $display("FAIL full_refill got %0d exp 4", outs_cnt); end
        icb_rsp_valid = 1'b1;
        for (int k = 0; k < 4; k++) cyc();
        icb_rsp_valid = 1'b0;
        n_chk++; if (outs_cnt !== 3'd0) begin n_fail++; $display("FAIL full_drain got %0d exp 0", outs_cnt); end
        clear_inputs();
    endtask

    task automatic test_switch();
        logic [4:0] exp_v [3];
        exp_v[0] = 5'b00100; exp_v[1] = 5'b00100; exp_v[2] = 5'b10000;
        sel = 3'd2; sel_vld = 1'b1; m_cmd_valid = 5'b00100;
        cyc(); cyc();
        sel = 3'd4; m_cmd_valid = 5'b10000;
        #1;
        n_chk++; if (m_cmd_ready !== 5'b10000) begin n_fail++; $display("FAIL sw_ready got %b exp 10000", m_cmd_ready); end
        cyc();
        m_cmd_valid = '0;
        n_chk++; if (outs_cnt !== 3'd3) begin n_fail++; $display("FAIL sw_outs got %0d exp 3", outs_cnt); end
        icb_rsp_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_chk++; if (m_rsp_valid !== exp_v[k]) begin n_fail++; $display("FAIL sw_route%0d got %b exp %b", k, m_rsp_valid, exp_v[k]); end
            cyc();
        end
        icb_rsp_valid = 1'b0;
        n_chk++; if (outs_cnt !== 3'd0) begin n_fail++; $display("FAIL sw_drain got %0d exp 0", outs_cnt); end
        clear_inputs();
    endtask

    task automatic test_orphan();
        icb_rsp_valid = 1'b1; icb_rsp_rdata = 32'hBAD0_BAD0;
        #1;
        n_chk++; if (icb_rsp_ready !== 1'b1 || m_rsp_valid !== 5'b0 || orphan_rsp !== 1'b0)
            begin n_fail++; $display("FAIL orph_comb got rdy=%b rv=%b o=%b exp 1/0/0", icb_rsp_ready, m_rsp_valid, orphan_rsp); end
        cyc();
        icb_rsp_valid = 1'b0;
        n_chk++; if (orphan_rsp !== 1'b1 || outs_cnt !== 3'd0) begin n_fail++; $display("FAIL orph_set got o=%b outs=%0d exp 1/0", orphan_rsp, outs_cnt); end
        cyc(); cyc();
        n_chk++; if (orphan_rsp !== 1'b1) begin n_fail++; $display("FAIL orph_sticky got %b exp 1", orphan_rsp); end
        do_reset();
        n_chk++; if (orphan_rsp !== 1'b0) begin n_fail++; $display("FAIL orph_clear got %b exp 0", orphan_rsp); end
    endtask

    task automatic test_backpressure();
        logic [2:0] exp_c;
        sel = 3'd3; sel_vld = 1'b1; m_cmd_valid = 5'b01000;
        cyc();
        m_cmd_valid = '0;
        m_rsp_ready = 5'b10111; icb_rsp_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            m_cmd_valid = (k == 2) ? 5'b01000 : 5'b00000;
            #1;
            n_chk++; if (icb_rsp_ready !== 1'b0 || m_rsp_valid !== 5'b01000)
                begin n_fail++; $display("FAIL bp_hold%0d got rdy=%b rv=%b exp 0/01000", k, icb_rsp_ready, m_rsp_valid); end
            cyc();
            exp_c = (k < 2) ? 3'd1 : 3'd2;
            n_chk++; if (outs_cnt !== exp_c) begin n_fail++; $display("FAIL bp_outs%0d got %0d exp %0d", k, outs_cnt, exp_c); end
        end
        m_cmd_valid = '0; m_rsp_ready = '1;
        cyc(); cyc();
        icb_rsp_valid = 1'b0;
        n_chk++; if (outs_cnt !== 3'd0) begin n_fail++; $display("FAIL bp_drain got %0d exp 0", outs_cnt); end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        sel = 3'd0; sel_vld = 1'b1; m_cmd_valid = 5'b00001;
        cyc(); cyc();
        m_cmd_valid = '0;
        n_chk++; if (outs_cnt !== 3'd2) begin n_fail++; $display("FAIL rm_pre got %0d exp 2", outs_cnt); end
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++; if (outs_cnt !== 3'd0 || idle !== 1'b1) begin n_fail++; $display("FAIL rm_async got outs=%0d idle=%b exp 0/1", outs_cnt, idle); end
        cyc();
        rst_n = 1'b1;
        cyc();
        icb_rsp_valid = 1'b1;
        #1;
        n_chk++; if (m_rsp_valid !== 5'b0 || icb_rsp_ready !== 1'b1) begin n_fail++; $display("FAIL rm_stray got rv=%b rdy=%b exp 0/1", m_rsp_valid, icb_rsp_ready); end
        cyc();
        icb_rsp_valid = 1'b0;
        n_chk++; if (orphan_rsp !== 1'b1) begin n_fail++; $display("FAIL rm_orphan got %b exp 1", orphan_rsp); end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b1;
        #2;
        test_reset();
        test_reads();
        test_full();
        test_switch();
        test_orphan();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
